wash_run: RTL and testbench

WASH_RUN -- requirements
Module: wash_run

---
 rtl/wash_run.sv | 200 ++++++++++++++++++++
 tb/tb_wash_run.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/wash_run.sv
// wash_run: coin-wash program sequencer (balance check, wash/rinse/spin countdown, done pulse)
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   start      one-cycle request to run the selected program (honoured in IDLE/REJECT)
//   mode       program select 0..3
//   bal_in     entered balance, 3 BCD digits
//   bal_neg    entered balance is negative
//   pause_bt   one-cycle pause/resume request
//   busy       not idle
//   done       one-cycle completion pulse
//   err        program rejected (insufficient or negative balance)
//   bal_out    remaining balance, 3 BCD digits
//   time_bcd   seconds remaining in the program, 3 BCD digits
//   phase_led  one-hot phase: 001 wash, 010 rinse, 100 spin
// Build option: define WASH_PAUSE_EN to enable pause/resume.
module wash_run #(
    parameter int TICK_CYCLES = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [11:0] bal_in,
    input  logic        bal_neg,
    input  logic        pause_bt,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [11:0] bal_out,
    output logic [11:0] time_bcd,
    output logic [2:0]  phase_led
);
    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_WASH, S_RINSE, S_SPIN, S_PAUSED, S_REJECT, S_DONE
    } state_t;

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TICK_CYCLES - 1);
    localparam logic [3:0] PRICE [4] = '{4'd5, 4'd8, 4'd12, 4'd3};
    localparam logic [5:0] DUR_W [4] = '{6'd10, 6'd20, 6'd30, 6'd0};
    localparam logic [5:0] DUR_R [4] = '{6'd5, 6'd10, 6'd15, 6'd0};
    localparam logic [5:0] DUR_S [4] = '{6'd5, 6'd10, 6'd15, 6'd10};

    function automatic logic [11:0] bin2bcd(input logic [9:0] v);
        return {4'(v / 10'd100), 4'((v / 10'd10) % 10'd10), 4'(v % 10'd10)};
    endfunction

    // decrement by one second with borrow across BCD digits (100 -> 099)
    function automatic logic [11:0] dec_bcd(input logic [11:0] b);
        return (b[3:0] != 4'd0) ? b - 12'd1 :
               (b[7:4] != 4'd0) ? {b[11:8], b[7:4] - 4'd1, 4'd9} :
                                  {b[11:8] - 4'd1, 8'h99};
    endfunction

    function automatic logic [5:0] dur(input logic [1:0] m, input state_t s);
        return (s == S_WASH)  ? DUR_W[m] :
               (s == S_RINSE) ? DUR_R[m] :
               (s == S_SPIN)  ? DUR_S[m] : 6'd0;
    endfunction

    state_t         r_state, w_state;
    logic [1:0]     r_mode, w_mode;
    logic [11:0]    r_bal, w_bal;
    logic           r_neg, w_neg;
    logic [TW-1:0]  r_tick, w_tick;
    logic [5:0]     r_cnt, w_cnt;
    logic [11:0]    r_time, w_time;
    logic [11:0]    r_bal_out, w_bal_out;
    logic [9:0]     w_bal_bin, w_price, w_total;
    logic           w_ok, w_in_phase, w_tick_hit, w_end;
    state_t         w_first, w_after, w_led_src;

`ifdef WASH_PAUSE_EN
    // phase to resume and to show on the LEDs while paused
    state_t         r_pstate, w_pstate;
`else
    logic           w_unused_pause;
    assign w_unused_pause = pause_bt;
`endif

    assign w_bal_bin  = 10'(r_bal[11:8]) * 10'd100 + 10'(r_bal[7:4]) * 10'd10 + 10'(r_bal[3:0]);
    assign w_price    = 10'(PRICE[r_mode]);
    assign w_total    = 10'(DUR_W[r_mode]) + 10'(DUR_R[r_mode]) + 10'(DUR_S[r_mode]);
    assign w_ok       = !r_neg && (w_bal_bin >= w_price);
    assign w_first    = (DUR_W[r_mode] != 6'd0) ? S_WASH : (DUR_R[r_mode] != 6'd0) ? S_RINSE : S_SPIN;
    assign w_after    = (r_state == S_WASH && DUR_R[r_mode] != 6'd0) ? S_RINSE :
                        (r_state == S_SPIN) ? S_DONE : S_SPIN;
    assign w_in_phase = (r_state == S_WASH) || (r_state == S_RINSE) || (r_state == S_SPIN);
    assign w_tick_hit = w_in_phase && (r_tick == TMAX);
    // the tick that takes the phase counter to zero also loads the next phase
    assign w_end      = w_tick_hit && (r_cnt == 6'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_mode    <= '0;
            r_bal     <= '0;
            r_neg     <= 1'b0;
            r_tick    <= '0;
            r_cnt     <= '0;
            r_time    <= '0;
            r_bal_out <= '0;
`ifdef WASH_PAUSE_EN
            r_pstate  <= S_IDLE;
`endif
        end else begin
            r_state   <= w_state;
            r_mode    <= w_mode;
            r_bal     <= w_bal;
            r_neg     <= w_neg;
            r_tick    <= w_tick;
            r_cnt     <= w_cnt;
            r_time    <= w_time;
            r_bal_out <= w_bal_out;
`ifdef WASH_PAUSE_EN
            r_pstate  <= w_pstate;
`endif
        end
    end

    always_comb begin
        w_state   = r_state;
        w_mode    = r_mode;
        w_bal     = r_bal;
        w_neg     = r_neg;
        w_tick    = r_tick;
        w_cnt     = r_cnt;
        w_time    = r_time;
        w_bal_out = r_bal_out;
`ifdef WASH_PAUSE_EN
        w_pstate  = r_pstate;
`endif
        case (r_state)
            S_IDLE, S_REJECT: begin
                if (start) begin
                    w_state = S_CHECK;
                    w_mode  = mode;
                    w_bal   = bal_in;
                    w_neg   = bal_neg;
                end
            end
            S_CHECK: begin
                if (w_ok) begin
                    w_state   = w_first;
                    w_cnt     = dur(r_mode, w_first);
                    w_tick    = '0;
                    w_time    = bin2bcd(w_total);
                    w_bal_out = bin2bcd(w_bal_bin - w_price);
                end else begin
                    w_state   = S_REJECT;
                    w_time    = '0;
                    w_bal_out = r_bal;
                end
            end
            S_WASH, S_RINSE, S_SPIN: begin
                w_tick = w_tick_hit ? '0 : r_tick + TW'(1);
                if (w_tick_hit) begin
                    w_time = dec_bcd(r_time);
                    w_cnt  = r_cnt - 6'd1;
                end
                if (w_end) begin
                    w_state = w_after;
                    w_cnt   = dur(r_mode, w_after);
                end
`ifdef WASH_PAUSE_EN
                // counters advance on the pause edge, so a pause that lands on
                // a phase-end tick freezes the newly loaded phase
                if (pause_bt && w_state != S_DONE) begin
                    w_pstate = w_state;
                    w_state  = S_PAUSED;
                end
`endif
            end
`ifdef WASH_PAUSE_EN
            S_PAUSED: begin
                if (pause_bt) w_state = r_pstate;
            end
`endif
            S_DONE: begin
                w_state = S_IDLE;
                w_time  = '0;
            end
            default: w_state = S_IDLE;
        endcase
    end

`ifdef WASH_PAUSE_EN
    assign w_led_src = (r_state == S_PAUSED) ? r_pstate : r_state;
`else
    assign w_led_src = r_state;
`endif

    assign busy      = r_state != S_IDLE;
    assign done      = r_state == S_DONE;
    assign err       = r_state == S_REJECT;
    assign bal_out   = r_bal_out;
    assign time_bcd  = r_time;
    assign phase_led = {w_led_src == S_SPIN, w_led_src == S_RINSE, w_led_src == S_WASH};
endmodule

// File: tb/tb_wash_run.sv
// tb_wash_run: vector table plus scoreboard bench for wash_run at 10 cycles per tick
module tb_wash_run;
    typedef struct {
        logic [1:0]  mode;
        logic [11:0] bal;
        logic        neg;
        logic        err;
        logic [11:0] bal_o;
        logic [11:0] tm;
        logic [2:0]  led;
        int          secs;
        int          cycles;
    } vec_t;

    localparam int DW [4] = '{10, 20, 30, 0};
    localparam int DR [4] = '{5, 10, 15, 0};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = '0;
    logic [11:0] bal_in = '0;
    logic        bal_neg = 1'b0;
    logic        pause_bt = 1'b0;
    logic        busy, done, err;
    logic [11:0] bal_out, time_bcd;
    logic [2:0]  phase_led;

    int   errors = 0;
    int   checks = 0;
    vec_t sb[$];
    vec_t vt[8];
    vec_t cur;
    vec_t v;
    logic in_chk = 1'b0;
    logic chk_now;
    logic running = 1'b0;
    logic m_paused = 1'b0;
    int   len = 0;
    int   act = 0;
    int   extra;
    logic found;

    wash_run #(.TICK_CYCLES(10)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .bal_in(bal_in),
        .bal_neg(bal_neg), .pause_bt(pause_bt), .busy(busy), .done(done),
        .err(err), .bal_out(bal_out), .time_bcd(time_bcd), .phase_led(phase_led)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] to_bcd(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic logic [2:0] exp_led(input int m, input int e);
        return (e < DW[m]) ? 3'b001 : (e < DW[m] + DR[m]) ? 3'b010 : 3'b100;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // scoreboard consumer: compares on CHECK exit, then follows the countdown
    always @(negedge clk) begin
        if (!rst) begin
            in_chk   = 1'b0;
            running  = 1'b0;
            m_paused = 1'b0;
        end else begin
            if (done) begin
                if (!running) chk("spurious_done", 1, 0);
                else chk("run_length", len, cur.cycles);
                running = 1'b0;
            end else if (running) begin
                len++;
                if (!m_paused) act++;
                chk("time_bcd", time_bcd, to_bcd(cur.secs - (act - 1) / 10));
                chk("phase_led", phase_led, exp_led(cur.mode, (act - 1) / 10));
`ifdef WASH_PAUSE_EN
                if (pause_bt) m_paused = !m_paused;
`endif
            end
            chk_now = busy && !done && !err && phase_led == 3'b000;
            if (in_chk && !chk_now) begin
                if (sb.size() == 0) chk("sb_underflow", 1, 0);
                else begin
                    cur = sb.pop_front();
                    chk("err", err, cur.err);
                    chk("bal_out", bal_out, cur.bal_o);
                    chk("time_exit", time_bcd, cur.tm);
                    chk("led_exit", phase_led, cur.led);
                    running = !cur.err;
                    len = 1;
                    act = 1;
                end
            end
            in_chk = chk_now;
        end
    end

    task automatic do_start(input vec_t x);
        @(posedge clk);
        #1;
        mode    = x.mode;
        bal_in  = x.bal;
        bal_neg = x.neg;
        start   = 1'b1;
        sb.push_back(x);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        chk("idle_timeout", 1, 0);
    endtask

    task automatic run_vec(input vec_t x);
        do_start(x);
        if (x.err) repeat (2) @(negedge clk);
        else begin
            wait_idle(x.cycles + 20);
            chk("idle_bal", bal_out, x.bal_o);
            chk("idle_time", time_bcd, 0);
        end
    endtask

    initial begin
        vt[0] = '{2'd1, 12'h020, 1'b0, 1'b0, 12'h012, 12'h040, 3'b001, 40, 400};
        vt[1] = '{2'd0, 12'h004, 1'b0, 1'b1, 12'h004, 12'h000, 3'b000, 0, 0};
        vt[2] = '{2'd0, 12'h005, 1'b0, 1'b0, 12'h000, 12'h020, 3'b001, 20, 200};
        vt[3] = '{2'd3, 12'h099, 1'b1, 1'b1, 12'h099, 12'h000, 3'b000, 0, 0};
        vt[4] = '{2'd3, 12'h099, 1'b0, 1'b0, 12'h096, 12'h010, 3'b100, 10, 100};
        vt[5] = '{2'd2, 12'h100, 1'b0, 1'b0, 12'h088, 12'h060, 3'b001, 60, 600};
        vt[6] = '{2'd2, 12'h011, 1'b0, 1'b1, 12'h011, 12'h000, 3'b000, 0, 0};
        vt[7] = '{2'd2, 12'h012, 1'b0, 1'b0, 12'h000, 12'h060, 3'b001, 60, 600};

        #1 chk("reset_outputs", {busy, done, err, bal_out, time_bcd, phase_led}, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vt[i]);

`ifdef WASH_PAUSE_EN
        extra = 50;
`else
        extra = 0;
`endif
        v = vt[0];
        v.cycles = 400 + extra;
        do_start(v);
        repeat (50) @(posedge clk);
        #1 pause_bt = 1'b1;
        @(posedge clk);
        #1 pause_bt = 1'b0;
        repeat (49) @(posedge clk);
        #1 pause_bt = 1'b1;
        @(posedge clk);
        #1 pause_bt = 1'b0;
        wait_idle(600);
        chk("pause_idle_bal", bal_out, 12'h012);

        do_start(vt[0]);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            found = phase_led == 3'b010;
        end
        chk("reach_rinse", found, 1);
        repeat (20) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("midrun_reset", {busy, done, err, bal_out, time_bcd, phase_led}, 0);
        repeat (3) @(posedge clk);
        #1 chk("held_reset", {busy, done, err, bal_out, time_bcd, phase_led}, 0);
        rst = 1'b1;
        run_vec(vt[2]);

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
